// File: rtl/lcd_char_receiver_if.sv
// rtl/lcd_char_receiver_if.sv - HD44780-style 8-bit character LCD bus
interface lcd_char_receiver_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (
        output lcd_e, lcd_rs, lcd_rw, lcd_data_in,
        input  lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  lcd_e, lcd_rs, lcd_rw, lcd_data_in,
        output lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/lcd_char_receiver.sv
// rtl/lcd_char_receiver.sv - character LCD responder with 2x16 DDRAM shadow
module lcd_char_receiver #(
    parameter int E_SYNC_STAGES     = 2,
    parameter int CMD_BUSY_CYCLES   = 2,
    parameter int CLEAR_BUSY_CYCLES = 40
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    lcd_char_receiver_if.slave    lcd,
    input  logic [4:0]            rd_addr_i,
    output logic [7:0]            rd_char_o,
    output logic                  busy_o,
    output logic                  disp_on_o,
    output logic                  two_line_o,
    output logic                  wr_strobe_o,
    output logic                  cmd_strobe_o,
    output logic                  err_o
);
    localparam int CNT_W = 16;

    logic [E_SYNC_STAGES-1:0][10:0] sync_q;
    logic [10:0]      sync_last;
    logic             s_e, s_rs, s_rw;
    logic [7:0]       s_data;
    logic             e_prev_q, commit, busy;

    logic [7:0]       ddram_q [32];
    logic [4:0]       ac_q, ac_d, ac_step;
    logic             id_q, id_d;
    logic             disp_on_q, disp_on_d;
    logic             two_line_q, two_line_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic             fill_q, fill_d;
    logic [4:0]       fill_idx_q, fill_idx_d;
    logic             mem_we;
    logic [4:0]       mem_addr;
    logic [7:0]       mem_data;
    logic             cmd_ok;
    logic [7:0]       rd_char_q;

    assign sync_last = sync_q[E_SYNC_STAGES-1];
    assign s_e       = sync_last[10];
    assign s_rs      = sync_last[9];
    assign s_rw      = sync_last[8];
    assign s_data    = sync_last[7:0];
    assign commit    = e_prev_q & ~s_e;
    assign busy      = (busy_cnt_q != '0);
    assign ac_step   = id_q ? ac_q + 5'd1 : ac_q - 5'd1;

    // All bus lines share one synchronizer chain so RS/RW/DATA stay aligned with E
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q   <= '0;
            e_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[E_SYNC_STAGES-2:0],
                         {lcd.lcd_e, lcd.lcd_rs, lcd.lcd_rw, lcd.lcd_data_in}};
            e_prev_q <= s_e;
        end
    end

    // Transaction decode on the synced E falling edge, plus the clear-display fill sequencer
    always_comb begin
        ac_d         = ac_q;
        id_d         = id_q;
        disp_on_d    = disp_on_q;
        two_line_d   = two_line_q;
        fill_d       = fill_q;
        fill_idx_d   = fill_idx_q;
        busy_cnt_d   = busy ? busy_cnt_q - CNT_W'(1) : '0;
        mem_we       = 1'b0;
        mem_addr     = ac_q;
        mem_data     = s_data;
        cmd_ok       = 1'b1;
        wr_strobe_o  = 1'b0;
        cmd_strobe_o = 1'b0;
        err_o        = 1'b0;

        if (fill_q) begin
            mem_we     = 1'b1;
            mem_addr   = fill_idx_q;
            mem_data   = 8'h20;
            fill_idx_d = fill_idx_q + 5'd1;
            if (fill_idx_q == 5'd31) begin
                fill_d = 1'b0;
                ac_d   = 5'd0;
                id_d   = 1'b1;
            end
        end

        if (commit) begin
            if (s_rw) begin
                // Reads are never refused; a data read walks AC like a write does
                if (s_rs) ac_d = ac_step;
            end else if (busy) begin
                err_o = 1'b1;
            end else if (s_rs) begin
                mem_we      = 1'b1;
                mem_addr    = ac_q;
                mem_data    = s_data;
                ac_d        = ac_step;
                wr_strobe_o = 1'b1;
                busy_cnt_d  = CNT_W'(CMD_BUSY_CYCLES);
            end else begin
                busy_cnt_d = CNT_W'(CMD_BUSY_CYCLES);
                if (s_data[7]) begin
                    if (s_data[6:4] == 3'b000)      ac_d = {1'b0, s_data[3:0]};
                    else if (s_data[6:4] == 3'b100) ac_d = {1'b1, s_data[3:0]};
                    else                            cmd_ok = 1'b0;
                end else if (s_data[6]) begin
                    cmd_ok = 1'b0;
                end else if (s_data[5]) begin
                    two_line_d = s_data[3];
                end else if (s_data[4]) begin
                    two_line_d = two_line_q;
                end else if (s_data[3]) begin
                    disp_on_d = s_data[2];
                end else if (s_data[2]) begin
                    id_d = s_data[1];
                end else if (s_data[1]) begin
                    ac_d = 5'd0;
                end else if (s_data[0]) begin
                    fill_d     = 1'b1;
                    fill_idx_d = 5'd0;
                    busy_cnt_d = CNT_W'(CLEAR_BUSY_CYCLES);
                end
                if (cmd_ok) begin
                    cmd_strobe_o = 1'b1;
                end else begin
                    err_o      = 1'b1;
                    busy_cnt_d = busy_cnt_q;
                end
            end
        end
    end

    // Control state, busy timer and fill pointer
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ac_q       <= 5'd0;
            id_q       <= 1'b1;
            disp_on_q  <= 1'b0;
            two_line_q <= 1'b0;
            busy_cnt_q <= '0;
            fill_q     <= 1'b0;
            fill_idx_q <= 5'd0;
        end else begin
            ac_q       <= ac_d;
            id_q       <= id_d;
            disp_on_q  <= disp_on_d;
            two_line_q <= two_line_d;
            busy_cnt_q <= busy_cnt_d;
            fill_q     <= fill_d;
            fill_idx_q <= fill_idx_d;
        end
    end

    // DDRAM shadow; reset restores the blank-screen contents
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
        end else if (mem_we) begin
            ddram_q[mem_addr] <= mem_data;
        end
    end

    // Registered character read port
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rd_char_q <= 8'h00;
        else          rd_char_q <= ddram_q[rd_addr_i];
    end

    assign rd_char_o        = rd_char_q;
    assign busy_o           = busy;
    assign disp_on_o        = disp_on_q;
    assign two_line_o       = two_line_q;
    assign lcd.lcd_data_oe  = s_e & s_rw;
    // Line 2 starts at HD44780 address 0x40, hence AC[4] lands in bit 6
    assign lcd.lcd_data_out = !(s_e & s_rw) ? 8'h00 :
                              s_rs          ? ddram_q[ac_q] :
                                              {busy, ac_q[4], 2'b00, ac_q[3:0]};
endmodule

// File: tb/tb_lcd_char_receiver.sv
// tb/tb_lcd_char_receiver.sv - scoreboard bench for lcd_char_receiver
module tb_lcd_char_receiver;
    localparam int CMD_BUSY = 12;
    localparam int CLR_BUSY = 40;

    typedef enum int {K_CMD, K_WR, K_ERR, K_RD, K_BUSY, K_CHAR, K_FLAGS} kind_t;
    typedef struct {
        kind_t kind;
        int    val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       busy, disp_on, two_line, wr_strobe, cmd_strobe, err;
    logic       probe_char_req, probe_flag_req, probe_char_q, probe_flag_q;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   rd_last = 0;
    bit   oe_prev = 1'b0;
    int   busy_len = 0;

    lcd_char_receiver_if lcd ();

    lcd_char_receiver #(
        .E_SYNC_STAGES    (2),
        .CMD_BUSY_CYCLES  (CMD_BUSY),
        .CLEAR_BUSY_CYCLES(CLR_BUSY)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .lcd         (lcd.slave),
        .rd_addr_i   (rd_addr),
        .rd_char_o   (rd_char),
        .busy_o      (busy),
        .disp_on_o   (disp_on),
        .two_line_o  (two_line),
        .wr_strobe_o (wr_strobe),
        .cmd_strobe_o(cmd_strobe),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        probe_char_q <= probe_char_req;
        probe_flag_q <= probe_flag_req;
    end

    function automatic void check(kind_t k, int act);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s unexpected event: actual %0h, nothing expected", k.name(), act);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.val != act) begin
                fails++;
                $display("FAIL %s: actual %0h, required %s %0h", k.name(), act, e.kind.name(), e.val);
            end
        end
    endfunction

    // Monitor: every DUT-presented event pops the next expectation
    always @(negedge clk) begin
        if (cmd_strobe) check(K_CMD, 1);
        if (wr_strobe)  check(K_WR, 1);
        if (err)        check(K_ERR, 1);
        if (lcd.lcd_data_oe) begin
            rd_last = {24'd0, lcd.lcd_data_out};
            oe_prev = 1'b1;
        end else if (oe_prev) begin
            check(K_RD, rd_last);
            oe_prev = 1'b0;
        end
        if (!rst_n) busy_len = 0;
        else if (busy) busy_len++;
        else if (busy_len != 0) begin
            check(K_BUSY, busy_len);
            busy_len = 0;
        end
        if (probe_char_q) check(K_CHAR, {24'd0, rd_char});
        if (probe_flag_q) check(K_FLAGS, {28'd0, lcd.lcd_data_oe, busy, disp_on, two_line});
    end

    function automatic void expect_ev(kind_t k, int v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endfunction

    task automatic bus(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd.lcd_rs = rs; lcd.lcd_rw = rw; lcd.lcd_data_in = d; lcd.lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd.lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: busy still %0b, required 0", busy);
        end
    endtask

    task automatic cmd(input logic [7:0] b);
        expect_ev(K_CMD, 1);
        expect_ev(K_BUSY, (b == 8'h01) ? CLR_BUSY : CMD_BUSY);
        bus(1'b0, 1'b0, b);
        wait_idle();
    endtask

    task automatic wr(input logic [7:0] d);
        expect_ev(K_WR, 1);
        expect_ev(K_BUSY, CMD_BUSY);
        bus(1'b1, 1'b0, d);
        wait_idle();
    endtask

    task automatic bad_cmd(input logic [7:0] b);
        expect_ev(K_ERR, 1);
        bus(1'b0, 1'b0, b);
        wait_idle();
    endtask

    task automatic rd(input logic rs, input int exp);
        expect_ev(K_RD, exp);
        bus(rs, 1'b1, 8'h00);
        wait_idle();
    endtask

    task automatic probe_char(input logic [4:0] a, input int exp);
        @(negedge clk);
        rd_addr = a;
        expect_ev(K_CHAR, exp);
        probe_char_req = 1'b1;
        @(negedge clk);
        probe_char_req = 1'b0;
    endtask

    task automatic probe_flags(input int exp);
        @(negedge clk);
        expect_ev(K_FLAGS, exp);
        probe_flag_req = 1'b1;
        @(negedge clk);
        probe_flag_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] clock_str [8];
        clock_str = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36};
        rst_n = 1'b0;
        lcd.lcd_e = 1'b0; lcd.lcd_rs = 1'b0; lcd.lcd_rw = 1'b0; lcd.lcd_data_in = 8'h00;
        rd_addr = 5'd0;
        probe_char_req = 1'b0;
        probe_flag_req = 1'b0;

        // Reset state
        probe_flags(0);
        probe_char(5'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        probe_char(5'd0, 8'h20);
        probe_char(5'd31, 8'h20);

        // Init sequence
        cmd(8'h3C);
        cmd(8'h0C);
        cmd(8'h06);
        probe_flags(4'b0011);

        // Watch text on line 1
        cmd(8'h80);
        for (int i = 0; i < 8; i++) wr(clock_str[i]);
        for (int i = 0; i < 8; i++) probe_char(5'(i), clock_str[i]);
        rd(1'b0, 8'h08);
        cmd(8'h80);
        rd(1'b1, 8'h31);
        rd(1'b0, 8'h01);

        // Wrap 31 -> 0 with ID=1, and 0 -> 31 with ID=0
        cmd(8'hCF);
        wr(8'h41);
        wr(8'h42);
        probe_char(5'd31, 8'h41);
        probe_char(5'd0, 8'h42);
        rd(1'b0, 8'h01);
        cmd(8'h04);
        cmd(8'h80);
        wr(8'h43);
        probe_char(5'd0, 8'h43);
        rd(1'b0, 8'h4F);

        // Write while busy is refused
        cmd(8'h06);
        cmd(8'h80);
        expect_ev(K_WR, 1);
        expect_ev(K_ERR, 1);
        expect_ev(K_BUSY, CMD_BUSY);
        bus(1'b1, 1'b0, 8'h55);
        bus(1'b1, 1'b0, 8'h66);
        wait_idle();
        probe_char(5'd0, 8'h55);
        probe_char(5'd1, 8'h32);
        rd(1'b0, 8'h01);

        // Illegal DDRAM address and CGRAM access
        bad_cmd(8'h90);
        rd(1'b0, 8'h01);
        bad_cmd(8'h40);
        rd(1'b0, 8'h01);

        // Clear display
        cmd(8'h01);
        for (int i = 0; i < 32; i++) probe_char(5'(i), 8'h20);
        rd(1'b0, 8'h00);
        probe_flags(4'b0011);

        // Reset during the clear fill
        wr(8'h58);
        probe_char(5'd0, 8'h58);
        expect_ev(K_CMD, 1);
        bus(1'b0, 1'b0, 8'h01);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        probe_flags(0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) probe_char(5'(i), 8'h20);
        rd(1'b0, 8'h00);
        probe_flags(0);

        repeat (5) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
